// File: rtl/cavlc_mb_sequencer.sv
// Macroblock sequencer for the CAVLC block decoder: walks the 4x4 luma blocks
// in raster order, pulses BlockEnable once per block, predicts nC from the
// left/top neighbour TotalCoeff and accumulates the macroblock coefficient sum.
module cavlc_mb_sequencer #(
  parameter int unsigned NUM_BLOCKS     = 16,
  parameter int unsigned TIMEOUT_CYCLES = 1023
) (
  input  logic       Clk,
  input  logic       nReset,
  input  logic       MbStart,
  input  logic       MbAbort,
  input  logic       BlockDone,
  input  logic [4:0] TotalCoeff,
  output logic       BlockEnable,
  output logic [3:0] BlockIdx,
  output logic [4:0] nC,
  output logic       MbBusy,
  output logic       MbDone,
  output logic       MbTimeout,
  output logic [8:0] MbCoeffSum
);

  typedef enum logic [2:0] {
    StIdle,
    StIssue,
    StWaitDone,
    StStore,
    StDone
  } stateT;

  localparam logic [3:0] LastIdx = 4'(NUM_BLOCKS - 1);
  localparam logic [9:0] CntLast = 10'(TIMEOUT_CYCLES - 1);

  stateT      stateQ, stateD;
  logic [3:0] blkIdxQ, blkIdxD;
  logic [9:0] cntQ, cntD;
  logic [4:0] holdQ, holdD;
  logic [8:0] sumQ, sumD;
  logic       timeoutQ, timeoutD;
  logic       clrTab, wrTab;
  logic [4:0] coeffTab [16];

  // State, counters and the per-block TotalCoeff table
  always_ff @(posedge Clk) begin
    if (!nReset) begin
      stateQ   <= StIdle;
      blkIdxQ  <= 4'd0;
      cntQ     <= 10'd0;
      holdQ    <= 5'd0;
      sumQ     <= 9'd0;
      timeoutQ <= 1'b0;
      for (int i = 0; i < 16; i++) coeffTab[i] <= 5'd0;
    end else begin
      stateQ   <= stateD;
      blkIdxQ  <= blkIdxD;
      cntQ     <= cntD;
      holdQ    <= holdD;
      sumQ     <= sumD;
      timeoutQ <= timeoutD;
      if (clrTab) begin
        for (int i = 0; i < 16; i++) coeffTab[i] <= 5'd0;
      end else if (wrTab) begin
        coeffTab[blkIdxQ] <= holdQ;
      end
    end
  end

  // Next-state logic; abort overrides every other transition
  always_comb begin
    stateD   = stateQ;
    blkIdxD  = blkIdxQ;
    cntD     = cntQ;
    holdD    = holdQ;
    sumD     = sumQ;
    timeoutD = 1'b0;
    clrTab   = 1'b0;
    wrTab    = 1'b0;
    if (MbAbort) begin
      stateD = StIdle;
    end else begin
      unique case (stateQ)
        StIdle: begin
          if (MbStart) begin
            stateD  = StIssue;
            blkIdxD = 4'd0;
            sumD    = 9'd0;
            clrTab  = 1'b1;
          end
        end
        StIssue: begin
          cntD   = 10'd0;
          stateD = StWaitDone;
        end
        StWaitDone: begin
          if (BlockDone) begin
            holdD  = TotalCoeff;
            stateD = StStore;
          end else begin
            cntD = cntQ + 10'd1;
            if (cntQ == CntLast) begin
              timeoutD = 1'b1;
              stateD   = StIdle;
            end
          end
        end
        StStore: begin
          wrTab = 1'b1;
          sumD  = sumQ + {4'd0, holdQ};
          if (blkIdxQ == LastIdx) begin
            stateD = StDone;
          end else begin
            blkIdxD = blkIdxQ + 4'd1;
            stateD  = StIssue;
          end
        end
        StDone: begin
          stateD = StIdle;
        end
        default: begin
          stateD = StIdle;
        end
      endcase
    end
  end

  logic       availA, availB;
  logic [4:0] nA, nB;
  logic [5:0] sumAB;

  // nC prediction from left (idx-1) and top (idx-4) neighbours
  always_comb begin
    availA = (blkIdxQ[1:0] != 2'd0);
    availB = (blkIdxQ[3:2] != 2'd0);
    nA     = coeffTab[blkIdxQ - 4'd1];
    nB     = coeffTab[blkIdxQ - 4'd4];
    sumAB  = {1'b0, nA} + {1'b0, nB} + 6'd1;
    if (availA && availB) begin
      nC = sumAB[5:1];
    end else if (availA) begin
      nC = nA;
    end else if (availB) begin
      nC = nB;
    end else begin
      nC = 5'd0;
    end
  end

  assign BlockEnable = (stateQ == StIssue);
  assign BlockIdx    = blkIdxQ;
  assign MbBusy      = (stateQ != StIdle);
  assign MbDone      = (stateQ == StDone);
  assign MbTimeout   = timeoutQ;
  assign MbCoeffSum  = sumQ;

endmodule

// File: tb/tb_cavlc_mb_sequencer.sv
// Directed self-checking bench for cavlc_mb_sequencer (TIMEOUT_CYCLES = 8).
module tb_cavlc_mb_sequencer;

  logic       Clk = 1'b0;
  logic       nReset;
  logic       MbStart;
  logic       MbAbort;
  logic       BlockDone;
  logic [4:0] TotalCoeff;
  logic       BlockEnable;
  logic [3:0] BlockIdx;
  logic [4:0] nC;
  logic       MbBusy;
  logic       MbDone;
  logic       MbTimeout;
  logic [8:0] MbCoeffSum;

  cavlc_mb_sequencer #(
    .NUM_BLOCKS    (16),
    .TIMEOUT_CYCLES(8)
  ) dut (
    .Clk        (Clk),
    .nReset     (nReset),
    .MbStart    (MbStart),
    .MbAbort    (MbAbort),
    .BlockDone  (BlockDone),
    .TotalCoeff (TotalCoeff),
    .BlockEnable(BlockEnable),
    .BlockIdx   (BlockIdx),
    .nC         (nC),
    .MbBusy     (MbBusy),
    .MbDone     (MbDone),
    .MbTimeout  (MbTimeout),
    .MbCoeffSum (MbCoeffSum)
  );

  always #5 Clk = ~Clk;

  typedef int arr16T [16];

  int nChecks = 0;
  int nFails  = 0;
  int enCount = 0;
  int cyc     = 0;
  int enStart;
  int savedSum;
  arr16T tc, expNc;

  // Count BlockEnable pulses, sampled mid-cycle
  always @(negedge Clk) if (BlockEnable === 1'b1) enCount++;

  task automatic tick();
    @(posedge Clk);
    #1;
    cyc++;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nChecks++;
    assert (obs === exp) else begin
      nFails++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // One whole macroblock with BlockDone one cycle after each BlockEnable
  task automatic runMb(input arr16T tcv, input arr16T ncv, input int expSum,
                       input int expCycles);
    MbStart = 1'b1;
    cyc     = 1;
    enStart = enCount;
    tick();
    MbStart = 1'b0;
    for (int b = 0; b < 16; b++) begin
      check($sformatf("enable blk%0d", b), BlockEnable, 1);
      check($sformatf("idx blk%0d", b), BlockIdx, b);
      check($sformatf("nC blk%0d", b), nC, ncv[b]);
      tick();
      BlockDone  = 1'b1;
      TotalCoeff = 5'(tcv[b]);
      tick();
      BlockDone = 1'b0;
      check($sformatf("store idx blk%0d", b), BlockIdx, b);
      tick();
    end
    check("mbdone pulse", MbDone, 1);
    check("mbdone cycle", cyc, expCycles);
    check("coeff sum", MbCoeffSum, expSum);
    check("enable count", enCount - enStart, 16);
    tick();
    check("busy after done", MbBusy, 0);
    check("mbdone one cycle", MbDone, 0);
  endtask

  initial begin
    nReset     = 1'b0;
    MbStart    = 1'b0;
    MbAbort    = 1'b0;
    BlockDone  = 1'b0;
    TotalCoeff = 5'd0;
    tick();
    tick();
    check("rst enable", BlockEnable, 0);
    check("rst idx", BlockIdx, 0);
    check("rst nC", nC, 0);
    check("rst busy", MbBusy, 0);
    check("rst done", MbDone, 0);
    check("rst timeout", MbTimeout, 0);
    check("rst sum", MbCoeffSum, 0);
    nReset = 1'b1;
    tick();

    // TotalCoeff = idx; nC hand-computed from left/top neighbours
    tc    = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11, 12, 13, 14, 15};
    expNc = '{0, 0, 1, 2, 0, 3, 4, 5, 4, 7, 8, 9, 8, 11, 12, 13};
    runMb(tc, expNc, 120, 50);

    // All 16: saturating neighbours, sum reaches 256
    tc    = '{16, 16, 16, 16, 16, 16, 16, 16, 16, 16, 16, 16, 16, 16, 16, 16};
    expNc = '{0, 16, 16, 16, 16, 16, 16, 16, 16, 16, 16, 16, 16, 16, 16, 16};
    runMb(tc, expNc, 256, 50);

    // idx1=3, idx4=4, rest 0: nC(5) = (3+4+1)>>1 = 4
    tc    = '{0, 3, 0, 0, 4, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    expNc = '{0, 0, 3, 0, 0, 4, 0, 0, 4, 0, 0, 0, 0, 0, 0, 0};
    runMb(tc, expNc, 7, 50);

    // Timeout: BlockDone never comes after the first BlockEnable
    MbStart = 1'b1;
    tick();
    MbStart = 1'b0;
    check("to enable", BlockEnable, 1);
    for (int k = 1; k <= 8; k++) begin
      tick();
      check($sformatf("to wait busy %0d", k), MbBusy, 1);
      check($sformatf("to wait flag %0d", k), MbTimeout, 0);
    end
    tick();
    check("to pulse", MbTimeout, 1);
    check("to busy", MbBusy, 0);
    check("to no done", MbDone, 0);
    tick();
    check("to pulse one cycle", MbTimeout, 0);

    // BlockDone on the final allowed wait cycle beats the timeout
    MbStart = 1'b1;
    tick();
    MbStart = 1'b0;
    for (int k = 1; k <= 8; k++) tick();
    BlockDone  = 1'b1;
    TotalCoeff = 5'd5;
    tick();
    BlockDone = 1'b0;
    check("edge store busy", MbBusy, 1);
    check("edge no timeout", MbTimeout, 0);
    tick();
    check("edge next enable", BlockEnable, 1);
    check("edge next idx", BlockIdx, 1);
    check("edge next nC", nC, 5);
    MbAbort = 1'b1;
    tick();
    MbAbort = 1'b0;
    check("edge abort busy", MbBusy, 0);

    // Abort together with BlockDone at idx 7
    MbStart = 1'b1;
    tick();
    MbStart = 1'b0;
    for (int b = 0; b < 7; b++) begin
      tick();
      BlockDone  = 1'b1;
      TotalCoeff = 5'd1;
      tick();
      BlockDone = 1'b0;
      tick();
    end
    check("abort at idx7", BlockIdx, 7);
    tick();
    BlockDone = 1'b1;
    MbAbort   = 1'b1;
    enStart   = enCount;
    tick();
    BlockDone = 1'b0;
    MbAbort   = 1'b0;
    check("abort busy", MbBusy, 0);
    check("abort no done", MbDone, 0);
    check("abort sum kept", MbCoeffSum, 7);
    tick();
    tick();
    tick();
    check("abort no enable", enCount - enStart, 0);
    // Abort wins over a simultaneous start
    MbStart = 1'b1;
    MbAbort = 1'b1;
    tick();
    MbStart = 1'b0;
    MbAbort = 1'b0;
    check("abort beats start", MbBusy, 0);
    MbStart = 1'b1;
    tick();
    MbStart = 1'b0;
    check("restart enable", BlockEnable, 1);
    check("restart idx", BlockIdx, 0);
    check("restart sum", MbCoeffSum, 0);
    check("restart nC", nC, 0);

    // MbStart during WAIT_DONE is ignored
    tick();
    MbStart = 1'b1;
    tick();
    MbStart = 1'b0;
    check("ign start enable", BlockEnable, 0);
    check("ign start idx", BlockIdx, 0);
    check("ign start busy", MbBusy, 1);
    BlockDone  = 1'b1;
    TotalCoeff = 5'd2;
    tick();
    BlockDone = 1'b0;
    tick();
    check("ign start next idx", BlockIdx, 1);
    check("ign start next en", BlockEnable, 1);
    MbAbort = 1'b1;
    tick();
    MbAbort = 1'b0;
    // BlockDone in IDLE is ignored
    savedSum   = 2;
    BlockDone  = 1'b1;
    TotalCoeff = 5'd9;
    tick();
    BlockDone = 1'b0;
    check("ign done busy", MbBusy, 0);
    check("ign done enable", BlockEnable, 0);
    tick();
    check("ign done sum", MbCoeffSum, savedSum);

    // Synchronous reset in the middle of a macroblock
    MbStart = 1'b1;
    tick();
    MbStart = 1'b0;
    tick();
    BlockDone  = 1'b1;
    TotalCoeff = 5'd3;
    tick();
    BlockDone = 1'b0;
    tick();
    tick();
    check("pre-rst nC", nC, 3);
    nReset = 1'b0;
    tick();
    nReset = 1'b1;
    check("mid rst enable", BlockEnable, 0);
    check("mid rst idx", BlockIdx, 0);
    check("mid rst nC", nC, 0);
    check("mid rst busy", MbBusy, 0);
    check("mid rst done", MbDone, 0);
    check("mid rst timeout", MbTimeout, 0);
    check("mid rst sum", MbCoeffSum, 0);
    MbStart = 1'b1;
    tick();
    MbStart = 1'b0;
    check("post rst enable", BlockEnable, 1);
    check("post rst idx", BlockIdx, 0);
    tick();
    BlockDone  = 1'b1;
    TotalCoeff = 5'd6;
    tick();
    BlockDone = 1'b0;
    tick();
    check("post rst idx1", BlockIdx, 1);
    check("post rst nC", nC, 6);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
